// File: rtl/snail_arbiter_ctrl_if.sv
// Requester and result handshake bundle for snail_arbiter_ctrl.
//
// Handshake rule, used by every valid/ready pair in this bundle: a transfer
// happens on a rising clk edge where valid and ready are both high. The
// producer holds valid (and its data) steady until that edge. Ready may
// depend on valid in the same cycle. The producer never waits for ready
// before raising valid.
interface snail_arbiter_ctrl_if;
  logic       in0_valid;
  logic [7:0] in0_data;
  logic       in0_ready;
  logic       in1_valid;
  logic [7:0] in1_data;
  logic       in1_ready;
  logic       res_valid;
  logic [3:0] res_count;
  logic       res_src;
  logic       res_ready;

  // Environment side: offers words, consumes results.
  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, res_ready,
    input  in0_ready, in1_ready, res_valid, res_count, res_src
  );

  // Controller side: accepts words, offers results.
  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, res_ready,
    output in0_ready, in1_ready, res_valid, res_count, res_src
  );
endinterface

// File: rtl/snail_arbiter_ctrl.sv
// Two-requester front end for a shared serial "two ones in a row" detector.
// Each granted word is cleared into the detector, shifted MSB first, drained
// for the detector's two-cycle latency, and the number of detector hits is
// returned together with the index of the requester that supplied the word.
module snail_arbiter_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  snail_arbiter_ctrl_if.slave  bus,
  output logic                 det_d,
  output logic                 det_rst_n,
  input  logic                 det_q,
  output logic                 busy,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state;
  logic       prio;      // port that wins when both request
  logic [7:0] data_q;    // word being shifted, next bit always in [7]
  logic [2:0] bit_cnt;   // SHIFT bit index / DRAIN cycle index
  logic [3:0] count_q;   // detector hits for the current word
  logic       src_q;     // requester that supplied the current word
  logic       res_valid_q;

  logic       grant_any;
  logic       grant_idx;
  logic [3:0] count_inc;

  // Grant decode: ready is only offered in IDLE and never during reset.
  always_comb begin
    grant_any = (state == IDLE) && !rst && (bus.in0_valid || bus.in1_valid);
    grant_idx = (bus.in0_valid && bus.in1_valid) ? prio : bus.in1_valid;
    count_inc = (count_q == 4'd15) ? count_q : count_q + 4'd1;
  end

  assign bus.in0_ready = grant_any && !grant_idx;
  assign bus.in1_ready = grant_any &&  grant_idx;
  assign bus.res_valid = res_valid_q;
  assign bus.res_count = count_q;
  assign bus.res_src   = src_q;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

  // Controller FSM with registered detector drive and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prio        <= 1'b0;
      data_q      <= 8'h00;
      bit_cnt     <= 3'd0;
      count_q     <= 4'd0;
      src_q       <= 1'b0;
      res_valid_q <= 1'b0;
      det_d       <= 1'b0;
      det_rst_n   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          det_d     <= 1'b0;
          det_rst_n <= 1'b1;
          if (grant_any) begin
            data_q    <= grant_idx ? bus.in1_data : bus.in0_data;
            src_q     <= grant_idx;
            prio      <= ~grant_idx;
            det_rst_n <= 1'b0;
            state     <= CLR;
          end
        end
        CLR: begin
          count_q   <= 4'd0;
          det_rst_n <= 1'b1;
          det_d     <= data_q[7];
          data_q    <= {data_q[6:0], 1'b0};
          bit_cnt   <= 3'd0;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (det_q) count_q <= count_inc;
          if (bit_cnt == 3'd7) begin
            det_d   <= 1'b0;
            bit_cnt <= 3'd0;
            state   <= DRAIN;
          end else begin
            det_d   <= data_q[7];
            data_q  <= {data_q[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        DRAIN: begin
          // Two zero cycles let the last bit's hit reach det_q.
          det_d <= 1'b0;
          if (det_q) count_q <= count_inc;
          if (bit_cnt == 3'd1) begin
            bit_cnt     <= 3'd0;
            res_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        DONE: begin
          det_d <= 1'b0;
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          det_d       <= 1'b0;
          det_rst_n   <= 1'b1;
          res_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
